// File: rtl/i2s_tx_tdm_channel.sv
// TDM transmit channel: serialises TX FIFO words onto one data line, up to NUM_SLOTS
// slots per frame, with slot mask, word length, bit order and ws-to-data offset.
module i2s_tx_tdm_channel #(
    parameter int NUM_SLOTS = 8,
    parameter int DATA_W    = 32,
    parameter int OFFSET_W  = 9
) (
    input  logic                         sck_i,
    input  logic                         rst_i,
    input  logic                         ws_i,
    output logic                         sd_o,
    input  logic [DATA_W-1:0]            fifo_data_i,
    input  logic                         fifo_data_valid_i,
    output logic                         fifo_data_ready_o,
    output logic                         fifo_err_o,
    output logic                         frame_err_o,
    output logic                         busy_o,
    output logic [$clog2(NUM_SLOTS)-1:0] slot_o,
    input  logic                         cfg_en_i,
    input  logic [$clog2(NUM_SLOTS)-1:0] cfg_num_slots_i,
    input  logic [NUM_SLOTS-1:0]         cfg_slot_mask_i,
    input  logic [$clog2(DATA_W)-1:0]    cfg_num_bits_i,
    input  logic                         cfg_lsb_first_i,
    input  logic [OFFSET_W-1:0]          cfg_offset_i
);

    localparam int SLOT_W = $clog2(NUM_SLOTS);
    localparam int BIT_W  = $clog2(DATA_W);

    localparam logic [2:0] ST_IDLE    = 3'd0;
    localparam logic [2:0] ST_PRIME   = 3'd1;
    localparam logic [2:0] ST_WAIT_WS = 3'd2;
    localparam logic [2:0] ST_OFFSET  = 3'd3;
    localparam logic [2:0] ST_SHIFT   = 3'd4;

    logic [2:0]          state_q, state_d;
    logic [DATA_W-1:0]   shadow_q, shadow_d;
    logic                shadow_full_q, shadow_full_d;
    logic [DATA_W-1:0]   shift_q, shift_d;
    logic [BIT_W-1:0]    bit_cnt_q, bit_cnt_d;
    logic [OFFSET_W-1:0] off_cnt_q, off_cnt_d;
    logic [SLOT_W-1:0]   slot_q, slot_d;
    logic                sd_q, sd_d;
    logic                fifo_err_q, fifo_err_d;
    logic                frame_err_q, frame_err_d;

    logic                capture_s;
    logic                consume_s;
    logic                start_s;
    logic                load_s;
    logic                load_first_s;
    logic                load_mask_s;
    logic [DATA_W-1:0]   load_word_s;
    logic [SLOT_W-1:0]   next_slot_s;

    // Position in the loaded word of the cnt-th transmitted bit of a slot.
    function automatic logic [BIT_W-1:0] bit_idx(input logic [BIT_W-1:0] cnt,
                                                 input logic [BIT_W-1:0] nb,
                                                 input logic             lsb);
        if (lsb) begin
            bit_idx = cnt;
        end else begin
            bit_idx = nb - cnt;
        end
    endfunction

    assign fifo_data_ready_o = (state_q != ST_IDLE) && !shadow_full_q;
    assign capture_s         = fifo_data_valid_i && fifo_data_ready_o;
    assign next_slot_s       = slot_q + SLOT_W'(1);

    assign sd_o        = sd_q;
    assign fifo_err_o  = fifo_err_q;
    assign frame_err_o = frame_err_q;
    assign busy_o      = (state_q == ST_OFFSET) || (state_q == ST_SHIFT);
    assign slot_o      = slot_q;

    // Frame sequencing, slot loads and shadow refill.
    always_comb begin
        state_d       = state_q;
        shadow_d      = shadow_q;
        shadow_full_d = shadow_full_q;
        shift_d       = shift_q;
        bit_cnt_d     = bit_cnt_q;
        off_cnt_d     = off_cnt_q;
        slot_d        = slot_q;
        sd_d          = sd_q;
        fifo_err_d    = 1'b0;
        frame_err_d   = 1'b0;
        consume_s     = 1'b0;
        start_s       = 1'b0;
        load_s        = 1'b0;
        load_first_s  = 1'b0;
        load_mask_s   = 1'b0;
        load_word_s   = '0;

        case (state_q)
            ST_IDLE: begin
                sd_d = 1'b0;
                if (cfg_en_i) begin
                    state_d = ST_PRIME;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_PRIME: begin
                sd_d = 1'b0;
                if (capture_s) begin
                    state_d = ST_WAIT_WS;
                end else begin
                    state_d = ST_PRIME;
                end
            end
            ST_WAIT_WS: begin
                sd_d = 1'b0;
                if (ws_i) begin
                    start_s = 1'b1;
                end else begin
                    state_d = ST_WAIT_WS;
                end
            end
            ST_OFFSET: begin
                if (ws_i) begin
                    start_s     = 1'b1;
                    frame_err_d = 1'b1;
                end else if (off_cnt_q == '0) begin
                    load_s       = 1'b1;
                    load_first_s = 1'b1;
                end else begin
                    off_cnt_d = off_cnt_q - OFFSET_W'(1);
                end
            end
            ST_SHIFT: begin
                if (bit_cnt_q == cfg_num_bits_i) begin
                    if (slot_q == cfg_num_slots_i) begin
                        // ws on the frame's final edge is a legal back-to-back frame
                        if (ws_i) begin
                            start_s = 1'b1;
                        end else begin
                            state_d = ST_WAIT_WS;
                            sd_d    = 1'b0;
                            slot_d  = '0;
                        end
                    end else if (ws_i) begin
                        start_s     = 1'b1;
                        frame_err_d = 1'b1;
                    end else begin
                        load_s = 1'b1;
                    end
                end else if (ws_i) begin
                    start_s     = 1'b1;
                    frame_err_d = 1'b1;
                end else begin
                    bit_cnt_d = bit_cnt_q + BIT_W'(1);
                    sd_d      = shift_q[bit_idx(bit_cnt_q + BIT_W'(1), cfg_num_bits_i,
                                                cfg_lsb_first_i)];
                end
            end
            default: begin
                state_d = ST_IDLE;
                sd_d    = 1'b0;
            end
        endcase

        if (start_s) begin
            slot_d = '0;
            if (cfg_offset_i == '0) begin
                load_s       = 1'b1;
                load_first_s = 1'b1;
            end else begin
                state_d   = ST_OFFSET;
                off_cnt_d = cfg_offset_i - OFFSET_W'(1);
                sd_d      = 1'b0;
            end
        end else begin
            off_cnt_d = off_cnt_d;
        end

        if (load_s) begin
            load_mask_s = load_first_s ? cfg_slot_mask_i[0] : cfg_slot_mask_i[next_slot_s];
            if (load_mask_s && shadow_full_q) begin
                load_word_s = shadow_q;
                consume_s   = 1'b1;
            end else begin
                load_word_s = '0;
                fifo_err_d  = load_mask_s;
            end
            state_d   = ST_SHIFT;
            slot_d    = load_first_s ? '0 : next_slot_s;
            bit_cnt_d = '0;
            shift_d   = load_word_s;
            sd_d      = load_word_s[bit_idx('0, cfg_num_bits_i, cfg_lsb_first_i)];
        end else begin
            shift_d = shift_d;
        end

        if (consume_s) begin
            shadow_full_d = 1'b0;
        end else begin
            shadow_full_d = shadow_full_q;
        end
        if (capture_s) begin
            shadow_d      = fifo_data_i;
            shadow_full_d = 1'b1;
        end else begin
            shadow_d = shadow_q;
        end

        // Disable wins over everything: flush the shadow and go quiet.
        if (!cfg_en_i) begin
            state_d       = ST_IDLE;
            shadow_full_d = 1'b0;
            sd_d          = 1'b0;
            slot_d        = '0;
            bit_cnt_d     = '0;
            off_cnt_d     = '0;
            fifo_err_d    = 1'b0;
            frame_err_d   = 1'b0;
        end else begin
            state_d = state_d;
        end
    end

    // State and output registers with synchronous reset.
    always_ff @(posedge sck_i) begin
        if (rst_i) begin
            state_q       <= ST_IDLE;
            shadow_q      <= '0;
            shadow_full_q <= 1'b0;
            shift_q       <= '0;
            bit_cnt_q     <= '0;
            off_cnt_q     <= '0;
            slot_q        <= '0;
            sd_q          <= 1'b0;
            fifo_err_q    <= 1'b0;
            frame_err_q   <= 1'b0;
        end else begin
            state_q       <= state_d;
            shadow_q      <= shadow_d;
            shadow_full_q <= shadow_full_d;
            shift_q       <= shift_d;
            bit_cnt_q     <= bit_cnt_d;
            off_cnt_q     <= off_cnt_d;
            slot_q        <= slot_d;
            sd_q          <= sd_d;
            fifo_err_q    <= fifo_err_d;
            frame_err_q   <= frame_err_d;
        end
    end

endmodule

// File: tb/tb_i2s_tx_tdm_channel.sv
// Bench for i2s_tx_tdm_channel: table of frame configurations plus hand-written
// frame-error, back-to-back and disable/reset sequences, checked bit-by-bit.
module tb_i2s_tx_tdm_channel;

    logic        sck_i = 1'b0;
    logic        rst_i;
    logic        ws_i;
    logic        sd_o;
    logic [31:0] fifo_data_i;
    logic        fifo_data_valid_i;
    logic        fifo_data_ready_o;
    logic        fifo_err_o;
    logic        frame_err_o;
    logic        busy_o;
    logic [2:0]  slot_o;
    logic        cfg_en_i;
    logic [2:0]  cfg_num_slots_i;
    logic [7:0]  cfg_slot_mask_i;
    logic [4:0]  cfg_num_bits_i;
    logic        cfg_lsb_first_i;
    logic [8:0]  cfg_offset_i;

    i2s_tx_tdm_channel #(.NUM_SLOTS(8), .DATA_W(32), .OFFSET_W(9)) dut (
        .sck_i             (sck_i),
        .rst_i             (rst_i),
        .ws_i              (ws_i),
        .sd_o              (sd_o),
        .fifo_data_i       (fifo_data_i),
        .fifo_data_valid_i (fifo_data_valid_i),
        .fifo_data_ready_o (fifo_data_ready_o),
        .fifo_err_o        (fifo_err_o),
        .frame_err_o       (frame_err_o),
        .busy_o            (busy_o),
        .slot_o            (slot_o),
        .cfg_en_i          (cfg_en_i),
        .cfg_num_slots_i   (cfg_num_slots_i),
        .cfg_slot_mask_i   (cfg_slot_mask_i),
        .cfg_num_bits_i    (cfg_num_bits_i),
        .cfg_lsb_first_i   (cfg_lsb_first_i),
        .cfg_offset_i      (cfg_offset_i)
    );

    always #5 sck_i = ~sck_i;

    typedef struct packed {
        logic [2:0]       ns;
        logic [7:0]       mask;
        logic [4:0]       nb;
        logic             lsb;
        logic [8:0]       off;
        int               nw;
        logic [3:0][31:0] w;
        int               exp_err;
        int               exp_cons;
    } vec_t;

    vec_t        vecs [6];
    logic [31:0] fifo_q [$];
    logic        sb [$];
    int          n_checks = 0;
    int          n_err = 0;
    int          n_consumed = 0;
    int          n_fifo_err = 0;
    int          n_frame_err = 0;
    int          b_cons, b_ferr, b_frerr;

    // FIFO source model: present the queue head, pop on handshake.
    always @(negedge sck_i) begin
        fifo_data_valid_i = (fifo_q.size() > 0);
        fifo_data_i       = (fifo_q.size() > 0) ? fifo_q[0] : 32'h0;
    end
    always @(posedge sck_i) begin
        if (fifo_data_valid_i && fifo_data_ready_o) begin
            void'(fifo_q.pop_front());
            n_consumed++;
        end
    end

    // Pulse counters for the error outputs.
    always @(negedge sck_i) begin
        if (fifo_err_o)  n_fifo_err++;
        if (frame_err_o) n_frame_err++;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic vec_t mk(input logic [2:0] ns, input logic [7:0] mask, input logic [4:0] nb,
                                input logic lsb, input logic [8:0] off, input int nw,
                                input logic [31:0] w0, input logic [31:0] w1,
                                input logic [31:0] w2, input logic [31:0] w3,
                                input int exp_err, input int exp_cons);
        vec_t v;
        v.ns = ns; v.mask = mask; v.nb = nb; v.lsb = lsb; v.off = off; v.nw = nw;
        v.w[0] = w0; v.w[1] = w1; v.w[2] = w2; v.w[3] = w3;
        v.exp_err = exp_err; v.exp_cons = exp_cons;
        return v;
    endfunction

    task automatic push_slot(input logic [31:0] w, input logic [4:0] nb, input logic lsb);
        for (int b = 0; b <= int'(nb); b++) begin
            sb.push_back(lsb ? w[b] : w[int'(nb) - b]);
        end
    endtask

    task automatic push_zeros(input int n);
        for (int b = 0; b < n; b++) sb.push_back(1'b0);
    endtask

    task automatic build(input vec_t v);
        int wi = 0;
        push_zeros(int'(v.off));
        for (int s = 0; s <= int'(v.ns); s++) begin
            if (v.mask[s]) begin
                if (wi < v.nw) begin
                    push_slot(v.w[wi], v.nb, v.lsb);
                    wi++;
                end else begin
                    push_zeros(int'(v.nb) + 1);
                end
            end else begin
                push_zeros(int'(v.nb) + 1);
            end
        end
        push_zeros(2);
    endtask

    task automatic set_cfg(input logic [2:0] ns, input logic [7:0] mask, input logic [4:0] nb,
                           input logic lsb, input logic [8:0] off);
        cfg_num_slots_i = ns; cfg_slot_mask_i = mask; cfg_num_bits_i = nb;
        cfg_lsb_first_i = lsb; cfg_offset_i = off;
    endtask

    task automatic snap();
        b_cons = n_consumed; b_ferr = n_fifo_err; b_frerr = n_frame_err;
    endtask

    // Pulse ws, then compare sd_o against the scoreboard one bit per edge.
    task automatic run_stream(input int ws_at, input int slot_j);
        int  j = 0;
        logic e;
        @(negedge sck_i); ws_i = 1'b1;
        @(negedge sck_i); ws_i = 1'b0;
        while (sb.size() > 0) begin
            e = sb.pop_front();
            check($sformatf("sd_bit%0d", j), {31'd0, sd_o}, {31'd0, e});
            if (j == 0) check("busy_active", {31'd0, busy_o}, 32'd1);
            if (j == slot_j) check("slot_one", {29'd0, slot_o}, 32'd1);
            ws_i = (j == ws_at);
            j++;
            @(negedge sck_i);
        end
        ws_i = 1'b0;
        check("busy_end", {31'd0, busy_o}, 32'd0);
        check("slot_end", {29'd0, slot_o}, 32'd0);
    endtask

    task automatic check_counts(input string tag, input int err, input int frerr, input int cons);
        repeat (2) @(negedge sck_i);
        check({tag, "_fifo_err"},  n_fifo_err - b_ferr,   err);
        check({tag, "_frame_err"}, n_frame_err - b_frerr, frerr);
        check({tag, "_consumed"},  n_consumed - b_cons,   cons);
    endtask

    initial begin
        vecs[0] = mk(3'd3, 8'h0F, 5'd15, 1'b0, 9'd0, 4, 32'hA5F0, 32'h1234, 32'h8001, 32'hFFFF, 0, 4);
        vecs[1] = mk(3'd3, 8'h0F, 5'd15, 1'b1, 9'd1, 4, 32'hA5F0, 32'h1234, 32'h8001, 32'hFFFF, 0, 4);
        vecs[2] = mk(3'd3, 8'h0A, 5'd15, 1'b0, 9'd0, 2, 32'hA5F0, 32'h1234, 32'h0, 32'h0, 0, 2);
        vecs[3] = mk(3'd3, 8'h0F, 5'd15, 1'b0, 9'd0, 2, 32'h0F0F, 32'h7A61, 32'h0, 32'h0, 2, 2);
        vecs[4] = mk(3'd3, 8'h0F, 5'd15, 1'b0, 9'd0, 4, 32'h1357, 32'h2468, 32'hFACE, 32'h0001, 0, 4);
        vecs[5] = mk(3'd1, 8'h03, 5'd7, 1'b0, 9'd3, 2, 32'hDEADBE5A, 32'h000000C3, 32'h0, 32'h0, 0, 2);

        rst_i = 1'b1; ws_i = 1'b0; cfg_en_i = 1'b0;
        fifo_data_i = 32'h0; fifo_data_valid_i = 1'b0;
        set_cfg(3'd3, 8'h0F, 5'd15, 1'b0, 9'd0);
        repeat (3) @(negedge sck_i);
        check("rst_sd",        {31'd0, sd_o},              32'd0);
        check("rst_ready",     {31'd0, fifo_data_ready_o}, 32'd0);
        check("rst_fifo_err",  {31'd0, fifo_err_o},        32'd0);
        check("rst_frame_err", {31'd0, frame_err_o},       32'd0);
        check("rst_busy",      {31'd0, busy_o},            32'd0);
        check("rst_slot",      {29'd0, slot_o},            32'd0);
        rst_i = 1'b0;

        for (int v = 0; v < 6; v++) begin
            @(negedge sck_i);
            set_cfg(vecs[v].ns, vecs[v].mask, vecs[v].nb, vecs[v].lsb, vecs[v].off);
            cfg_en_i = 1'b1;
            snap();
            for (int i = 0; i < vecs[v].nw; i++) fifo_q.push_back(vecs[v].w[i]);
            repeat (4) @(negedge sck_i);
            build(vecs[v]);
            run_stream(-1, int'(vecs[v].off) + int'(vecs[v].nb) + 2);
            check_counts($sformatf("vec%0d", v), vecs[v].exp_err, 0, vecs[v].exp_cons);
        end

        // ws in the middle of slot 1: restart with the next shadow word.
        set_cfg(3'd3, 8'h0F, 5'd15, 1'b0, 9'd0);
        snap();
        fifo_q = '{32'hC001, 32'h0F0F, 32'h3C3C, 32'h5A5A, 32'h9669, 32'hE007};
        repeat (4) @(negedge sck_i);
        push_slot(32'hC001, 5'd15, 1'b0);
        for (int b = 15; b >= 11; b--) sb.push_back(1'b0 ^ (b == 15 ? 1'b0 : 1'b0) | (32'h0F0F >> b) & 32'h1);
        push_slot(32'h3C3C, 5'd15, 1'b0);
        push_slot(32'h5A5A, 5'd15, 1'b0);
        push_slot(32'h9669, 5'd15, 1'b0);
        push_slot(32'hE007, 5'd15, 1'b0);
        push_zeros(2);
        run_stream(20, 17);
        check_counts("midws", 0, 1, 6);

        // ws on the last bit of a frame: gapless next frame, no error.
        set_cfg(3'd1, 8'h03, 5'd3, 1'b0, 9'd0);
        snap();
        fifo_q = '{32'hFFFF_FFFA, 32'h5, 32'hC, 32'h3};
        repeat (4) @(negedge sck_i);
        push_slot(32'hA, 5'd3, 1'b0);
        push_slot(32'h5, 5'd3, 1'b0);
        push_slot(32'hC, 5'd3, 1'b0);
        push_slot(32'h3, 5'd3, 1'b0);
        push_zeros(2);
        run_stream(7, 5);
        check_counts("b2b", 0, 0, 4);

        // Disable mid-slot, pulse reset, then re-enable and prime again.
        set_cfg(3'd3, 8'h0F, 5'd15, 1'b0, 9'd0);
        fifo_q = '{32'h1111, 32'h2222, 32'h3333, 32'h4444};
        repeat (4) @(negedge sck_i);
        @(negedge sck_i); ws_i = 1'b1;
        @(negedge sck_i); ws_i = 1'b0;
        repeat (20) @(negedge sck_i);
        cfg_en_i = 1'b0;
        @(negedge sck_i);
        check("dis_sd",    {31'd0, sd_o},              32'd0);
        check("dis_ready", {31'd0, fifo_data_ready_o}, 32'd0);
        check("dis_busy",  {31'd0, busy_o},            32'd0);
        fifo_q.delete();
        rst_i = 1'b1;
        @(negedge sck_i);
        rst_i = 1'b0;
        check("rst2_ready", {31'd0, fifo_data_ready_o}, 32'd0);
        check("rst2_slot",  {29'd0, slot_o},            32'd0);
        set_cfg(3'd2, 8'h07, 5'd15, 1'b0, 9'd0);
        snap();
        fifo_q = '{32'hBEEF, 32'h0001, 32'h8000};
        cfg_en_i = 1'b1;
        repeat (6) @(negedge sck_i);
        check("prime_one_word", n_consumed - b_cons, 32'd1);
        check("prime_ready",    {31'd0, fifo_data_ready_o}, 32'd0);
        push_slot(32'hBEEF, 5'd15, 1'b0);
        push_slot(32'h0001, 5'd15, 1'b0);
        push_slot(32'h8000, 5'd15, 1'b0);
        push_zeros(2);
        run_stream(-1, 17);
        check_counts("reenable", 0, 0, 3);

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule
